// File: rtl/atconv_pkg.sv
// Shared constants and state encoding for the ATCONV memory responder.
package atconv_pkg;

  localparam int DW        = 13;
  localparam int IMG_AW    = 12;
  localparam int L1_AW     = 10;
  localparam int IMG_DEPTH = 1 << IMG_AW;
  localparam int L1_DEPTH  = 1 << L1_AW;

  // Responder phases: image preload, wait for start, offer image, ATCONV busy,
  // stream results out, finished.
  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_ARMED = 3'd1,
    S_READY = 3'd2,
    S_RUN   = 3'd3,
    S_DUMP  = 3'd4,
    S_DONE  = 3'd5
  } resp_state_t;

endpackage

// File: rtl/atconv_sp_ram.sv
// Word-wide RAM: one synchronous write port and NRD asynchronous read ports.
// The layer memories need a second read port so the dump stream and ATCONV
// crd reads can run at the same time.
module atconv_sp_ram
  import atconv_pkg::*;
#(
  parameter int DEPTH = IMG_DEPTH,
  parameter int DW    = atconv_pkg::DW,
  parameter int NRD   = 1,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [DW-1:0]           wdata,
  input  logic [NRD-1:0][AW-1:0]  raddr,
  output logic [NRD-1:0][DW-1:0]  rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write at the rising edge; reads see the old word until then.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    assign rdata[gi] = mem[raddr[gi]];
  end

endmodule

// File: rtl/atconv_mem_resp.sv
// Memory-side responder for ATCONV: image store, Layer0/Layer1 result memories,
// ready/busy start handshake and a valid/ready dump of both layers.
// Optional macro RESP_WRCHK_EN: drop Layer1 writes above 1023 and flag oob_err.
module atconv_mem_resp
  import atconv_pkg::*;
#(
  parameter int DW     = atconv_pkg::DW,
  parameter int IMG_AW = atconv_pkg::IMG_AW,
  parameter int L1_AW  = atconv_pkg::L1_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DW-1:0]     load_data,
  input  logic              start,
  output logic              ready,
  input  logic              busy,
  input  logic [IMG_AW-1:0] iaddr,
  output logic [DW-1:0]     idata,
  input  logic              csel,
  input  logic              crd,
  input  logic [IMG_AW-1:0] caddr_rd,
  output logic [DW-1:0]     cdata_rd,
  input  logic              cwr,
  input  logic [IMG_AW-1:0] caddr_wr,
  input  logic [DW-1:0]     cdata_wr,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DW-1:0]     dump_data,
  output logic              dump_layer,
  output logic              dump_last,
  output logic              done,
  output logic              oob_err
);

  // Dump index runs over Layer0 then Layer1; the top bit selects Layer1.
  localparam int unsigned   DUMP_LAST_I = (1 << IMG_AW) + (1 << L1_AW) - 1;
  localparam logic [IMG_AW:0] DUMP_LAST = DUMP_LAST_I[IMG_AW:0];

  resp_state_t       state_q, state_d;
  logic [IMG_AW-1:0] load_cnt_q, load_cnt_d;
  logic [IMG_AW:0]   dump_cnt_q, dump_cnt_d;
  logic [DW-1:0]     hold_q, hold_d;
  logic              busy_seen_q, busy_seen_d;
  logic              oob_q, oob_d;

  logic              load_fire;
  logic              dump_fire;
  logic              acc_en;
  logic              l0_we;
  logic              l1_hit;
  logic              l1_we;
  logic              l1_oob;
  logic [DW-1:0]     rd_word;

  logic [0:0][IMG_AW-1:0] img_raddr;
  logic [0:0][DW-1:0]     img_rdata;
  logic [1:0][IMG_AW-1:0] l0_raddr;
  logic [1:0][DW-1:0]     l0_rdata;
  logic [1:0][L1_AW-1:0]  l1_raddr;
  logic [1:0][DW-1:0]     l1_rdata;

  // ---------------- memories ----------------
  assign img_raddr[0] = iaddr;
  assign l0_raddr[0]  = caddr_rd;
  assign l0_raddr[1]  = dump_cnt_q[IMG_AW-1:0];
  assign l1_raddr[0]  = caddr_rd[L1_AW-1:0];
  assign l1_raddr[1]  = dump_cnt_q[L1_AW-1:0];

  atconv_sp_ram #(.DEPTH(1 << IMG_AW), .DW(DW), .NRD(1)) u_img (
    .clk   (clk),
    .we    (load_fire),
    .waddr (load_cnt_q),
    .wdata (load_data),
    .raddr (img_raddr),
    .rdata (img_rdata)
  );

  atconv_sp_ram #(.DEPTH(1 << IMG_AW), .DW(DW), .NRD(2)) u_layer0 (
    .clk   (clk),
    .we    (l0_we),
    .waddr (caddr_wr),
    .wdata (cdata_wr),
    .raddr (l0_raddr),
    .rdata (l0_rdata)
  );

  atconv_sp_ram #(.DEPTH(1 << L1_AW), .DW(DW), .NRD(2)) u_layer1 (
    .clk   (clk),
    .we    (l1_we),
    .waddr (caddr_wr[L1_AW-1:0]),
    .wdata (cdata_wr),
    .raddr (l1_raddr),
    .rdata (l1_rdata)
  );

  assign idata = img_rdata[0];

  // ---------------- layer access ----------------
  // ATCONV may touch the layers in every phase except the image preload.
  assign acc_en  = (state_q != S_LOAD);
  assign l0_we   = cwr & ~csel & acc_en;
  assign l1_hit  = cwr & csel & acc_en;

`ifdef RESP_WRCHK_EN
  assign l1_oob  = l1_hit & (caddr_wr[IMG_AW-1:L1_AW] != '0);
  assign l1_we   = l1_hit & ~l1_oob;
`else
  // Upper write-address bits are ignored: Layer1 writes alias modulo its depth.
  logic unused_wr_hi;
  assign unused_wr_hi = ^caddr_wr[IMG_AW-1:L1_AW];
  assign l1_oob  = 1'b0;
  assign l1_we   = l1_hit;
`endif

  // Read data is live while crd is high, otherwise the last captured word.
  assign rd_word  = csel ? l1_rdata[0] : l0_rdata[0];
  assign cdata_rd = (crd & acc_en) ? rd_word : hold_q;
  assign hold_d   = cdata_rd;
  assign oob_d    = oob_q | l1_oob;
  assign oob_err  = oob_q;

  // ---------------- dump datapath ----------------
  assign dump_layer = dump_cnt_q[IMG_AW];
  assign dump_data  = dump_layer ? l1_rdata[1] : l0_rdata[1];

  assign load_fire = load_valid & load_ready;
  assign dump_fire = dump_valid & dump_ready;

  // State register and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      load_cnt_q  <= '0;
      dump_cnt_q  <= '0;
      hold_q      <= '0;
      busy_seen_q <= 1'b0;
      oob_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      dump_cnt_q  <= dump_cnt_d;
      hold_q      <= hold_d;
      busy_seen_q <= busy_seen_d;
      oob_q       <= oob_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    dump_cnt_d  = dump_cnt_q;
    busy_seen_d = busy_seen_q;
    case (state_q)
      S_LOAD: begin
        if (load_fire) begin
          load_cnt_d = load_cnt_q + 1'b1;
          if (load_cnt_q == '1) begin
            state_d = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (start) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (busy) begin
          state_d     = S_RUN;
          busy_seen_d = 1'b1;
        end
      end
      S_RUN: begin
        if (busy) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          state_d     = S_DUMP;
          busy_seen_d = 1'b0;
          dump_cnt_d  = '0;
        end
      end
      S_DUMP: begin
        if (dump_fire) begin
          if (dump_cnt_q == DUMP_LAST) begin
            state_d    = S_DONE;
            dump_cnt_d = '0;
          end else begin
            dump_cnt_d = dump_cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_READY;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    load_ready = 1'b0;
    ready      = 1'b0;
    dump_valid = 1'b0;
    dump_last  = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_LOAD:  load_ready = 1'b1;
      S_READY: ready      = 1'b1;
      S_DUMP: begin
        dump_valid = 1'b1;
        dump_last  = (dump_cnt_q == DUMP_LAST);
      end
      S_DONE:  done       = 1'b1;
      default: ;
    endcase
  end

endmodule
